matmul_output_drain: RTL and testbench
======================================

MATMUL_OUTPUT_DRAIN -- requirements
Module: matmul_output_drain

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: bits per result element.
REQ-002 SHALL have parameter NUM_ROWS, default 8: rows per result tile, which is also the number of lanes per row.
REQ-003 SHALL have parameter AWIDTH, default 11: result RAM address width.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request to drain one tile; sampled in IDLE only.
REQ-007 SHALL have port clear_done, input, 1 bit: acknowledges done.
REQ-008 SHALL have port address_mat_c, input, AWIDTH bits: base address of row 0.
REQ-009 SHALL have port address_stride_c, input, 8 bits: address step between rows.
REQ-010 SHALL have port validity_mask_c_rows, input, NUM_ROWS bits: bit r=1 means row r is drained.
REQ-011 SHALL have port ram_en, output, 1 bit: read enable.
REQ-012 SHALL have port ram_addr, output, AWIDTH bits: read address.
REQ-013 SHALL have port ram_rdata, input, NUM_ROWS*DWIDTH bits: row data, valid exactly one cycle after ram_en.
REQ-014 SHALL have port out_valid, output, 1 bit: out_data/out_row/out_last are valid.
REQ-015 SHALL have port out_ready, input, 1 bit: consumer accepts the beat.
REQ-016 SHALL have port out_data, output, NUM_ROWS*DWIDTH bits: one result row.
REQ-017 SHALL have port out_row, output, log2(NUM_ROWS) bits: index of the emitted row.
REQ-018 SHALL have port out_last, output, 1 bit: this beat is the last enabled row.
REQ-019 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-020 SHALL have port done, output, 1 bit: tile fully delivered; held until cleared.

Function
REQ-021 SHALL implement FSM states IDLE, READ, FLUSH and DONE.
REQ-022 SHALL, in IDLE with start=1, latch address_mat_c, address_stride_c and validity_mask_c_rows, then go to READ; if the latched mask is 0, SHALL go to DONE instead.
REQ-023 SHALL, in READ, issue at most one read per cycle, visiting enabled rows in ascending order and skipping rows whose mask bit is 0.
REQ-024 SHALL compute the address for row r as base + r*stride, modulo 2^AWIDTH; wrap-around is legal.
REQ-025 SHALL hold a 2-entry buffer, and SHALL assert ram_en only when (buffer occupancy + reads in flight) < 2, so that no data is ever dropped under backpressure.
REQ-026 SHALL write ram_rdata into the buffer in the cycle after ram_en, tagged with its row index and a last flag.
REQ-027 SHALL set out_valid whenever the buffer is non-empty; a beat transfers when out_valid=1 and out_ready=1.
REQ-028 SHALL keep out_data, out_row and out_last stable while out_valid=1 and out_ready=0.
REQ-029 SHALL support simultaneous buffer write and transfer in one cycle, sustaining 1 beat per cycle when out_ready=1.
REQ-030 SHALL go from READ to FLUSH after the last enabled read is issued.
REQ-031 SHALL go from FLUSH to DONE in the cycle after the out_last beat transfers.
REQ-032 SHALL, in DONE, hold done=1; clear_done=1 SHALL return the FSM to IDLE on the next edge.
REQ-033 SHALL ignore start outside IDLE, including a start that arrives in the same cycle as clear_done.
REQ-034 SHALL ignore clear_done outside DONE.
REQ-035 SHALL have a minimum latency from start to first out_valid of 3 cycles: latch, read, buffer.

Reset
REQ-036 SHALL, while resetn=0, asynchronously force state=IDLE, buffer empty, in-flight reads=0, ram_en=0, ram_addr=0, out_valid=0, out_data=0, out_row=0, out_last=0, busy=0 and done=0.
REQ-037 SHALL, if reset asserts mid-drain, discard all in-flight reads and buffered rows; after release the block is IDLE and requires a new start.

Verification
REQ-038 SHALL cover: base=0, stride=8, mask=8'hFF, out_ready=1, RAM row r filled with byte r+1 -> 8 beats with out_row 0..7 on consecutive cycles, out_data bytes all equal r+1, out_last only on row 7, and done=1 one cycle after that beat.
REQ-039 SHALL cover: mask=8'b1010_0101 -> reads only at addresses 0, 16, 40 and 56; beats out_row 0, 2, 5, 7; out_last on row 7.
REQ-040 SHALL cover: out_ready toggled by a random pattern (including 10 consecutive low cycles) -> ram_en never asserted with 2 entries committed, no beat lost or duplicated, and outputs stable while stalled.
REQ-041 SHALL cover: base=11'h7F8, stride=8'h04, mask=8'hFF -> addresses 7F8, 7FC, 000, 004, ..., 014 (wrap-around).
REQ-042 SHALL cover: mask=0 -> no ram_en and no beats; done=1 two cycles after start; clear_done=1 -> IDLE; start held high during DONE has no effect.
REQ-043 SHALL cover: resetn pulsed low after the 3rd beat -> all outputs 0 immediately; a new start afterwards drains all 8 rows correctly.

Source files
------------

// File: rtl/matmul_output_drain_if.sv
// Result-RAM read port and result-row output stream of the output drain.
// master = drain side, slave = RAM/consumer side.
interface matmul_output_drain_if #(
    parameter int DWIDTH   = 8,
    parameter int NUM_ROWS = 8,
    parameter int AWIDTH   = 11
) ();
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    logic                       ram_en;
    logic [AWIDTH-1:0]          ram_addr;
    logic [NUM_ROWS*DWIDTH-1:0] ram_rdata;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_ROWS*DWIDTH-1:0] out_data;
    logic [RW-1:0]              out_row;
    logic                       out_last;

    modport master (
        output ram_en, ram_addr,
        input  ram_rdata,
        output out_valid, out_data, out_row, out_last,
        input  out_ready
    );

    modport slave (
        input  ram_en, ram_addr,
        output ram_rdata,
        input  out_valid, out_data, out_row, out_last,
        output out_ready
    );
endinterface

// File: rtl/matmul_output_drain.sv
// Drains the enabled rows of a result tile from RAM onto a valid/ready stream.
// Latency start->out_valid 3 cycles; reads are throttled so a 2-entry buffer absorbs any stall.
module matmul_output_drain #(
    parameter int DWIDTH   = 8,
    parameter int NUM_ROWS = 8,
    parameter int AWIDTH   = 11
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                clear_done,
    input  logic [AWIDTH-1:0]   address_mat_c,
    input  logic [7:0]          address_stride_c,
    input  logic [NUM_ROWS-1:0] validity_mask_c_rows,
    output logic                busy,
    output logic                done,
    matmul_output_drain_if.master bus
);
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int PW = RW + 8;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [NUM_ROWS*DWIDTH-1:0] data;
        logic [RW-1:0]              row;
        logic                       last;
    } entry_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_base;
    logic [7:0]          r_stride;
    logic [NUM_ROWS-1:0] r_pending;
    logic                r_inflight;
    logic [RW-1:0]       r_if_row;
    logic                r_if_last;
    entry_t              r_buf [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_latch;
    logic                w_rd_en;
    logic                w_pop;
    logic                w_room;
    logic                w_rd_last;
    logic [NUM_ROWS-1:0] w_rd_onehot;
    logic [RW-1:0]       w_rd_row;
    logic [PW-1:0]       w_offset;
    logic [AWIDTH-1:0]   w_addr;
    entry_t              w_head;

    // Lowest still-pending row is the next one to read; rows with mask 0 never enter r_pending.
    always_comb begin
        w_rd_onehot = r_pending & (~r_pending + NUM_ROWS'(1));
        w_rd_row    = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (w_rd_onehot[i]) begin
                w_rd_row = RW'(i);
            end
        end
        w_rd_last = (r_pending & ~w_rd_onehot) == '0;
        w_offset  = PW'(w_rd_row) * PW'(r_stride);
        w_addr    = r_base + AWIDTH'(w_offset);
        w_head    = r_buf[r_rd_ptr];
        w_pop     = (r_count != 2'd0) && bus.out_ready;
        // Count this cycle's pop so a full pipeline still sustains one row per cycle.
        w_room    = (3'(r_count) + 3'(r_inflight) - 3'(w_pop)) < 3'd2;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_rd_en     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = (validity_mask_c_rows == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (w_room) begin
                    w_rd_en = 1'b1;
                    if (w_rd_last) begin
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (w_pop && w_head.last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (clear_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base     <= '0;
            r_stride   <= '0;
            r_pending  <= '0;
            r_inflight <= 1'b0;
            r_if_row   <= '0;
            r_if_last  <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_latch) begin
                r_base    <= address_mat_c;
                r_stride  <= address_stride_c;
                r_pending <= validity_mask_c_rows;
            end else if (w_rd_en) begin
                r_pending <= r_pending & ~w_rd_onehot;
            end
            r_inflight <= w_rd_en;
            r_if_row   <= w_rd_row;
            r_if_last  <= w_rd_last;
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= '{data: bus.ram_rdata, row: r_if_row, last: r_if_last};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
        end
    end

    assign bus.ram_en    = w_rd_en;
    assign bus.ram_addr  = w_rd_en ? w_addr : '0;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = w_head.data;
    assign bus.out_row   = w_head.row;
    assign bus.out_last  = w_head.last;
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
endmodule

// File: tb/tb_matmul_output_drain.sv
// Randomised scoreboard bench for matmul_output_drain with a behavioural RAM and tile model.
module tb_matmul_output_drain;
    localparam int DW = 8;
    localparam int NR = 8;
    localparam int AW = 11;

    typedef struct {
        logic [NR*DW-1:0] d;
        int               row;
        bit               last;
    } beat_t;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          clear_done;
    logic [AW-1:0] address_mat_c;
    logic [7:0]    address_stride_c;
    logic [NR-1:0] validity_mask_c_rows;
    logic          busy;
    logic          done;

    matmul_output_drain_if #(.DWIDTH(DW), .NUM_ROWS(NR), .AWIDTH(AW)) bus ();

    matmul_output_drain #(.DWIDTH(DW), .NUM_ROWS(NR), .AWIDTH(AW)) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .start                (start),
        .clear_done           (clear_done),
        .address_mat_c        (address_mat_c),
        .address_stride_c     (address_stride_c),
        .validity_mask_c_rows (validity_mask_c_rows),
        .busy                 (busy),
        .done                 (done),
        .bus                  (bus)
    );

    logic [NR*DW-1:0] ram [0:(1<<AW)-1];
    beat_t            exp_q[$];
    int               exp_addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    int low_run  = 0;
    int n_iss    = 0;
    int n_xfr    = 0;
    int total_beats = 0;
    int tile_beats  = 0;
    int start_cyc   = 0;
    int first_valid_cyc = -100;
    int first_beat_cyc  = -100;
    int last_beat_cyc   = -100;
    int done_exp_cyc    = -1;
    bit seen_valid = 0;
    bit prev_stall = 0;
    logic [NR*DW-1:0] prev_data;
    logic [2:0]       prev_row;
    logic             prev_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read data is only meaningful the cycle after ram_en; otherwise present garbage.
    always @(posedge clk) bus.ram_rdata <= bus.ram_en ? ram[bus.ram_addr] : {$urandom, $urandom};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred with no expectation pending (cycle %0d)", nm, cyc);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                bus.out_ready = 1'b1;
            end else if (low_run > 0) begin
                bus.out_ready = 1'b0;
                low_run--;
            end else begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 31) == 0) low_run = 10;
            end
        end
    end

    always @(negedge clk) begin
        int    xfer;
        int    a;
        beat_t b;
        if (!resetn) begin
            n_iss        = 0;
            n_xfr        = 0;
            prev_stall   = 0;
            done_exp_cyc = -1;
        end else begin
            xfer = (bus.out_valid && bus.out_ready) ? 1 : 0;
            if (prev_stall)
                chk("stall_stable", {bus.out_valid, bus.out_data, bus.out_row, bus.out_last},
                    {1'b1, prev_data, prev_row, prev_last});
            if (bus.ram_en) begin
                chk("ram_en_room", ((n_iss - n_xfr - xfer) < 2), 1);
                if (exp_addr_q.size() == 0) begin
                    fail_now("unexpected_read");
                end else begin
                    a = exp_addr_q.pop_front();
                    chk("ram_addr", bus.ram_addr, a);
                end
            end
            if (bus.out_valid && !seen_valid) begin
                seen_valid      = 1;
                first_valid_cyc = cyc;
            end
            if (xfer != 0) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", bus.out_data, b.d);
                    chk("beat_row", bus.out_row, b.row);
                    chk("beat_last", bus.out_last, b.last);
                end
                if (tile_beats == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                tile_beats++;
                total_beats++;
                if (bus.out_last) begin
                    chk("done_before_last", done, 0);
                    done_exp_cyc = cyc + 1;
                end
            end
            if (cyc == done_exp_cyc) chk("done_after_last", done, 1);
            n_iss      = n_iss + (bus.ram_en ? 1 : 0);
            n_xfr      = n_xfr + xfer;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_row   = bus.out_row;
            prev_last  = bus.out_last;
        end
    end

    task automatic start_tile(input int base, input int stride, input int mask,
                              input int mode, output int nbeats);
        int hi;
        beat_t b;
        hi = -1;
        nbeats = 0;
        for (int r = 0; r < NR; r++) if (mask[r]) hi = r;
        for (int r = 0; r < NR; r++) begin
            if (mask[r]) begin
                int a;
                a = (base + r * stride) % (1 << AW);
                exp_addr_q.push_back(a);
                b.d    = ram[a];
                b.row  = r;
                b.last = (r == hi);
                exp_q.push_back(b);
                nbeats++;
            end
        end
        @(posedge clk);
        #1;
        address_mat_c        = AW'(base);
        address_stride_c     = 8'(stride);
        validity_mask_c_rows = NR'(mask);
        rdy_mode   = mode;
        if (mode != 0) low_run = 10;
        tile_beats = 0;
        seen_valid = 0;
        first_valid_cyc = -100;
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_tile(input int nbeats, input bit rdy_always, input bit noise);
        bit got;
        got = 0;
        for (int w = 0; w < 3000; w++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                break;
            end
            if (noise) begin
                start      = ($urandom_range(0, 1) == 1);
                clear_done = ($urandom_range(0, 3) == 0);
            end
        end
        start      = 1'b0;
        clear_done = 1'b0;
        if (!got) $display("FAIL done_timeout: done never asserted within 3000 cycles");
        chk("done_set", got, 1);
        chk("tile_beats", tile_beats, nbeats);
        chk("model_queue_empty", exp_q.size() + exp_addr_q.size(), 0);
        chk("first_valid_latency", first_valid_cyc - start_cyc, 3);
        if (rdy_always) chk("back_to_back", last_beat_cyc - first_beat_cyc, nbeats - 1);
        repeat (2) @(posedge clk);
        #1;
        chk("done_held", {busy, done}, 2'b11);
        clear_done = 1'b1;
        @(posedge clk);
        #1;
        clear_done = 1'b0;
        chk("cleared_idle", {busy, done}, 2'b00);
    endtask

    initial begin
        int nb;
        int iss0;
        int beats0;
        resetn     = 1'b0;
        start      = 1'b0;
        clear_done = 1'b0;
        address_mat_c        = '0;
        address_stride_c     = '0;
        validity_mask_c_rows = '0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = {$urandom, $urandom};
        for (int r = 0; r < NR; r++) ram[r * 8] = {NR{8'(r + 1)}};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.ram_en, bus.ram_addr, bus.out_valid, bus.out_data,
                              bus.out_row, bus.out_last, busy, done}, '0);
        resetn = 1'b1;

        // Full tile, stride 8, continuous ready.
        start_tile(0, 8, 8'hFF, 0, nb);
        finish_tile(nb, 1, 0);
        // Sparse mask.
        start_tile(0, 8, 8'hA5, 0, nb);
        finish_tile(nb, 1, 0);
        // Backpressure with a forced 10-cycle stall.
        start_tile(0, 8, 8'hFF, 1, nb);
        finish_tile(nb, 0, 0);
        // Address wrap-around.
        start_tile(11'h7F8, 8'h04, 8'hFF, 0, nb);
        finish_tile(nb, 1, 0);

        // Empty mask: no reads, done two cycles on, start ignored while done.
        iss0   = n_iss;
        beats0 = total_beats;
        @(posedge clk);
        #1;
        validity_mask_c_rows = '0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mask0_done", done, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("start_in_done_ignored", {busy, done}, 2'b11);
        clear_done = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        clear_done = 1'b0;
        chk("mask0_clear_idle", {busy, done}, 2'b00);
        @(posedge clk);
        #1;
        chk("mask0_stays_idle", {busy, done}, 2'b00);
        chk("mask0_no_read", n_iss - iss0, 0);
        chk("mask0_no_beat", total_beats - beats0, 0);

        // Reset in the middle of a drain, then a fresh full drain.
        start_tile(0, 8, 8'hFF, 0, nb);
        for (int w = 0; w < 200 && tile_beats < 3; w++) begin
            @(posedge clk);
            #1;
        end
        chk("three_beats_before_reset", tile_beats, 3);
        resetn = 1'b0;
        #1;
        chk("midreset_outputs", {bus.ram_en, bus.ram_addr, bus.out_valid, bus.out_data,
                                 bus.out_row, bus.out_last, busy, done}, '0);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_reset", {busy, done, bus.out_valid, bus.ram_en}, 4'b0000);
        start_tile(0, 8, 8'hFF, 0, nb);
        finish_tile(nb, 1, 0);

        // Random tiles with random backpressure and stray start/clear_done.
        for (int t = 0; t < 6; t++) begin
            int mode;
            mode = $urandom_range(0, 1);
            start_tile($urandom_range(0, (1 << AW) - 1), $urandom_range(0, 255),
                       $urandom_range(1, 255), mode, nb);
            finish_tile(nb, (mode == 0), 1);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
